// File: rtl/itch_pkg.sv
// Shared ITCH dispatcher definitions: ASCII message-type codes, FSM state enum,
// payload tracker type and a byte-extraction helper.
package itch_pkg;

    localparam logic [7:0] CODE_ORDER_ADD   = 8'h4F; // "O"
    localparam logic [7:0] CODE_TRADE       = 8'h54; // "T"
    localparam logic [7:0] CODE_ADD         = 8'h41; // "A"
    localparam logic [7:0] CODE_DELETE      = 8'h44; // "D"

    localparam logic [31:0] DEFAULT_TYPE_CODES =
        {CODE_ORDER_ADD, CODE_TRADE, CODE_ADD, CODE_DELETE};

    typedef logic [7:0] typeByte_t;
    typedef logic [5:0] tracker_t;

    // A type byte in the top byte lane leaves no payload in this word.
    localparam tracker_t LAST_BYTE_OFFSET = 6'd56;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DECODE = 3'd1,
        ST_DEFER  = 3'd2,
        ST_BUSY   = 3'd3,
        ST_RESYNC = 3'd4
    } dispatchState_t;

    function automatic typeByte_t byteAt(input logic [63:0] word, input tracker_t offset);
        return typeByte_t'(word >> offset);
    endfunction

endpackage

// File: rtl/itch_type_decode.sv
// Maps an ITCH type byte to a one-hot parser select and a known flag.
// Bit k of portSel corresponds to the k-th code listed in TYPE_CODE (leftmost first).
module itch_type_decode
    import itch_pkg::*;
#(
    parameter int                     NUM_TYPES = 4,
    parameter logic [NUM_TYPES*8-1:0] TYPE_CODE = {"O", "T", "A", "D"}
) (
    input  typeByte_t              typeByte,
    output logic [NUM_TYPES-1:0]   portSel,
    output logic                   known
);

    // First match wins so a duplicated code can never produce a multi-hot select.
    always_comb begin
        portSel = '0;
        known   = 1'b0;
        for (int k = 0; k < NUM_TYPES; k++) begin
            if (!known && typeByte == TYPE_CODE[(NUM_TYPES-1-k)*8 +: 8]) begin
                portSel[k] = 1'b1;
                known      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/itch_msg_dispatcher.sv
// ITCH stream dispatcher: finds each message type byte and hands the stream to one parser.
// Optional statistics counters are built when ITCH_DISPATCH_STATS_EN is defined.
module itch_msg_dispatcher
    import itch_pkg::*;
#(
    parameter int                     NUM_TYPES = 4,
    parameter logic [NUM_TYPES*8-1:0] TYPE_CODE = {"O", "T", "A", "D"}
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              dataIn,
    input  logic                     dataValid,
    input  logic                     sof,
    input  logic [NUM_TYPES-1:0]     parserEnd,
    input  logic [NUM_TYPES*6-1:0]   parserTracker,
    output logic [63:0]              dataOut,
    output logic [NUM_TYPES-1:0]     start,
    output logic [5:0]               trackerOut,
    output logic [7:0]               msgType,
    output logic                     err,
`ifdef ITCH_DISPATCH_STATS_EN
    output logic [NUM_TYPES*32-1:0]  msgCount,
    output logic [15:0]              errCount,
`endif
    output dispatchState_t           dbgState
);

    // dataValid qualifies dataIn, sof and parserEnd; there is no backpressure, so a low
    // dataValid freezes the whole block. start is a level held until the selected
    // parser returns parserEnd on a valid word.

    dispatchState_t        state;
    tracker_t              tracker;
    tracker_t              decodeTracker;
    tracker_t              endTracker;
    typeByte_t             typeByte;
    logic [NUM_TYPES-1:0]  sel;
    logic [NUM_TYPES-1:0]  portSel;
    logic                  known;
    logic                  doDecode;
    logic                  endHit;

    // sof is a resync point: its type byte always sits in lane 0.
    assign doDecode      = dataValid && (sof || state == ST_DECODE);
    assign decodeTracker = sof ? tracker_t'(0) : tracker;
    assign typeByte      = byteAt(dataIn, decodeTracker);
    assign dbgState      = state;

    itch_type_decode #(
        .NUM_TYPES (NUM_TYPES),
        .TYPE_CODE (TYPE_CODE)
    ) uTypeDecode (
        .typeByte (typeByte),
        .portSel  (portSel),
        .known    (known)
    );

    // Only the parser currently holding the stream may end it.
    always_comb begin
        endHit     = 1'b0;
        endTracker = '0;
        for (int k = 0; k < NUM_TYPES; k++) begin
            if (sel[k] && parserEnd[k]) begin
                endHit     = 1'b1;
                endTracker = parserTracker[k*6 +: 6];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            tracker    <= '0;
            sel        <= '0;
            start      <= '0;
            trackerOut <= '0;
            msgType    <= '0;
            dataOut    <= '0;
            err        <= 1'b0;
        end else if (dataValid) begin
            dataOut <= dataIn;
            if (doDecode) begin
                tracker <= decodeTracker;
                msgType <= typeByte;
                sel     <= portSel;
                if (sof) begin
                    err <= 1'b0;
                end
                if (!known) begin
                    err   <= 1'b1;
                    start <= '0;
                    state <= ST_RESYNC;
                end else if (decodeTracker == LAST_BYTE_OFFSET) begin
                    start <= '0;
                    state <= ST_DEFER;
                end else begin
                    start      <= portSel;
                    trackerOut <= decodeTracker + 6'd8;
                    state      <= ST_BUSY;
                end
            end else begin
                case (state)
                    ST_BUSY: begin
                        if (endHit) begin
                            start   <= '0;
                            tracker <= endTracker & 6'b111000;
                            state   <= ST_DECODE;
                        end
                    end
                    // Payload starts at bit 0 of the word after a top-lane type byte.
                    ST_DEFER: begin
                        start      <= sel;
                        trackerOut <= '0;
                        state      <= ST_BUSY;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ITCH_DISPATCH_STATS_EN
    logic [NUM_TYPES-1:0] startPrev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            startPrev <= '0;
            msgCount  <= '0;
            errCount  <= '0;
        end else begin
            startPrev <= start;
            for (int k = 0; k < NUM_TYPES; k++) begin
                if (start[k] && !startPrev[k]) begin
                    msgCount[k*32 +: 32] <= msgCount[k*32 +: 32] + 32'd1;
                end
            end
            if (doDecode && !known) begin
                errCount <= errCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: doc/itch_msg_dispatcher.md
ITCH_MSG_DISPATCHER -- requirements
Module: itch_msg_dispatcher

Interface
REQ-001 Parameter NUM_TYPES, default 4, number of parser ports; bit k of every vector port maps to the type code TYPE_CODE[k].
REQ-002 Parameter TYPE_CODE, default {"O","T","A","D"}, 8-bit ASCII message-type code per parser port.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 dataIn  input  64  packed ITCH stream word, little-endian byte order.
REQ-006 dataValid  input  1  dataIn holds a new word this cycle.
REQ-007 sof  input  1  with dataValid: a message type byte sits at bit 0 of dataIn (resync point).
REQ-008 parserEnd  input  NUM_TYPES  signal_end from each parser, one cycle before the parser's last word.
REQ-009 parserTracker  input  NUM_TYPES*6  trackerOut from each parser: bit offset of the next type byte.
REQ-010 dataOut  output  64  dataIn registered one cycle, aligned with start and trackerOut.
REQ-011 start  output  NUM_TYPES  level start to the selected parser, one-hot or zero.
REQ-012 trackerOut  output  6  payload bit offset handed to the selected parser.
REQ-013 msgType  output  8  type byte of the message in flight.
REQ-014 err  output  1  sticky unknown-type flag, cleared by sof.

Function
REQ-015 The block SHALL implement states IDLE, DECODE, DEFER, BUSY and RESYNC.
REQ-016 IDLE: on dataValid&sof SHALL set tracker=0 and go to DECODE with the same word.
REQ-017 DECODE: SHALL read typeByte=dataIn[tracker+:8]; tracker is always a multiple of 8.
REQ-018 Known type, tracker<=48: SHALL assert start[k], trackerOut=tracker+8 and dataOut=word on the next cycle, then go to BUSY.
REQ-019 Known type, tracker==56: SHALL go to DEFER; on the next valid word it SHALL assert start[k] with trackerOut=0.
REQ-020 Unknown type: SHALL set err and go to RESYNC with start all zero.
REQ-021 BUSY: start[k] SHALL stay high on every cycle until parserEnd[k] is sampled high; start SHALL drop the following cycle.
REQ-022 On parserEnd[k], the block SHALL latch parserTracker[k] as tracker; the next valid word SHALL be decoded in DECODE.
REQ-023 parserEnd on any port other than the selected k SHALL be ignored.
REQ-024 dataValid low SHALL stall the FSM; start, trackerOut and dataOut SHALL hold.
REQ-025 RESYNC: the block SHALL drop words until dataValid&sof, then behave as IDLE on that word.
REQ-026 sof arriving in BUSY or DEFER SHALL abort the message: start cleared, err cleared, and the word decoded at tracker 0.
REQ-027 Decode-to-start latency SHALL be exactly 1 cycle (REQ-018), or 1 valid word later in the DEFER case.

Reset
REQ-028 While rst=0 at an edge, the block SHALL set state=IDLE, tracker=0, start=0, trackerOut=0, msgType=0, dataOut=0 and err=0.
REQ-029 Reset mid-message SHALL drop start in the same edge; no parserEnd is required.

Configuration
REQ-030 The macro ITCH_DISPATCH_STATS_EN SHALL gate two ports: msgCount (NUM_TYPES*32) and errCount (16).
REQ-031 With the macro defined, each counter SHALL increment once per start rising edge or err set, wrap modulo 2^width, and reset to 0.
REQ-032 Without the macro, those ports and counters SHALL not exist and all other behaviour SHALL be unchanged.

Structure
REQ-033 Package itch_pkg SHALL hold the ASCII type-code constants, the dispatcher state enum and the 6-bit tracker typedef.
REQ-034 Sub-module itch_type_decode SHALL map an 8-bit type byte to a one-hot port select plus a known flag.

Verification
REQ-035 sof word 0x...4F at byte 0, parser 0 ends with parserTracker=32 -> start=0001, trackerOut=8, next decode at bit 32.
REQ-036 Type byte "T" at tracker 56 -> DEFER, start=0010 on the next valid word with trackerOut=0.
REQ-037 Type byte 0x5A -> err=1, start=0, words dropped; a later sof word "O" -> err=0, start=0001.
REQ-038 dataValid low for 3 cycles during BUSY -> start, dataOut and trackerOut held, no decode.
REQ-039 rst=0 during BUSY -> all outputs 0 the next cycle; after release, IDLE waits for sof.
REQ-040 Stats build: 5 "O" and 2 unknown messages -> msgCount[0]=5, errCount=2.
